theta_apply: RTL and testbench
==============================

Name: theta_apply

Overview:
Downstream neighbour of the column-parity stage in the matrix encoder datapath (theta step).
- LOAD phase: buffers the 64 per-slice 5-bit column-parity vectors produced upstream.
- APPLY phase: streams the 64 25-bit state slices through, XORing each with its theta correction. The result feeds the next permutation stage.
- Valid/ready handshakes on all streams; fixed 64-slice frame per start.

Parameters:
- SLICE_W, 25, bits per slice (5x5, bit i = 5*y + x); fixed, not overridable in practice.
- LANES, 5, columns per slice (x range).
- DEPTH, 64, slices per frame (z range).
- ZW, 6, width of slice index, equal to log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (block resets while rst==0).
- start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE.
- par_valid  in  1  parity vector valid.
- par_in  in  LANES  C[x][z] for x=0..4; vectors arrive in order z=0..63.
- par_ready  out  1  high only in LOAD.
- sin_valid  in  1  input slice valid.
- sin  in  SLICE_W  state slice A[.][.][z]; slices arrive in order z=0..63.
- sin_ready  out  1  in APPLY: !sout_valid || sout_ready; otherwise 0.
- sout_valid  out  1  output slice valid.
- sout  out  SLICE_W  A'[.][.][z].
- sout_ready  in  1  downstream accept.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst==0, async): state=IDLE, z=0, sout_valid=0, sout=0, done=0, busy=0, par_ready=0, sin_ready=0. The parity buffer is not reset; its contents are don't-care.
- FSM states are IDLE, LOAD, APPLY, DONE.
  - IDLE: on start -> LOAD, z=0. start in any other state is ignored.
  - LOAD: each par_valid&&par_ready writes buf[z]=par_in and increments z. On the handshake at z=63 -> APPLY, z wraps to 0.
  - APPLY: each sin_valid&&sin_ready registers sout = sin ^ D(z), sets sout_valid=1 and increments z.
    - Latency is 1 cycle, with full throughput under no backpressure.
    - sout and sout_valid hold stable while sout_valid&&!sout_ready.
    - sout_valid clears on an output handshake with no new input handshake in the same cycle.
    - A simultaneous output handshake and input handshake loads the new slice; sout_valid stays 1.
    - APPLY -> DONE on the output handshake of slice z=63.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Theta correction: D[x][z] = buf[z][(x+4)%5] ^ buf[(z+63)%64][(x+1)%5]. The same D[x] applies to all five rows: bit 5*y+x of sout = sin[5*y+x] ^ D[x][z].
- Wrap-around: slice z=0 uses buf[63]. All 64 vectors are loaded before APPLY, so no stall is needed.
- z arithmetic is modulo 64 in a ZW-bit counter with natural wrap.
- Reset mid-frame returns to IDLE immediately, discards any held output, and a new start is required.
- par_valid outside LOAD and sin_valid outside APPLY are ignored; ready is 0 in those states.

Decomposition:
- Shared package holds:
  - SLICE_W, LANES, DEPTH, ZW;
  - state encoding IDLE=2'd0, LOAD=2'd1, APPLY=2'd2, DONE=2'd3;
  - helper function for the x±1 mod 5 index.
- One sub-module, parity_buf: a DEPTH x LANES register file.
  - One synchronous write port, two asynchronous read ports (z and z-1).
  - No reset.
- The FSM, counter and output register stay in theta_apply.

Test Plan:
1. All-zero parities, slices sin=25'h0AAAAAA for z=0..63 -> sout==25'h0AAAAAA for every slice; done pulses once; busy falls the cycle after done.
2. Wrap-around: only buf[63]=5'b00001, all slices zero -> z=0 sout=25'h1084210, z=63 sout=25'h0210842, all other z give 0.
3. Backpressure: sout_ready toggles 0/1 every cycle during APPLY -> no slice lost or duplicated, sout stable while stalled, exactly 64 outputs, sin_ready low whenever sout_valid&&!sout_ready.
4. Full throughput: sout_ready=1, sin_valid=1 continuously -> 64 outputs in 64 consecutive cycles, first output 1 cycle after the first input handshake.
5. Reset mid-APPLY after 20 slices (rst=0 for 1 cycle) -> sout_valid=0, busy=0 asynchronously; a subsequent start plus full frame produces correct results.
6. start pulsed during LOAD and APPLY -> ignored; z sequence and output count are unaffected.

Source files
------------

// File: rtl/theta_apply_pkg.sv
// theta_apply_pkg: shared sizes, FSM encoding and lane index helper for the theta stage
package theta_apply_pkg;
    localparam int SLICE_W = 25;
    localparam int LANES   = 5;
    localparam int DEPTH   = 64;
    localparam int ZW      = 6;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] APPLY = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // (x + d) mod 5; d=1 gives x+1, d=4 gives x-1
    function automatic int lane_step(input int x, input int d);
        return (x + d) % LANES;
    endfunction
endpackage

// File: rtl/theta_apply_parity_buf.sv
// parity_buf: DEPTH x LANES column-parity register file, one write port, two async read ports
module parity_buf
    import theta_apply_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [ZW-1:0]    waddr,
    input  logic [LANES-1:0] wdata,
    input  logic [ZW-1:0]    raddr_a,
    output logic [LANES-1:0] rdata_a,
    input  logic [ZW-1:0]    raddr_b,
    output logic [LANES-1:0] rdata_b
);
    logic [LANES-1:0] mem [DEPTH];

    // contents are fully rewritten every frame before being read, so no reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/theta_apply.sv
// theta_apply: buffers 64 column-parity vectors, then XORs each state slice with its theta correction
module theta_apply
    import theta_apply_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               par_valid,
    input  logic [LANES-1:0]   par_in,
    output logic               par_ready,
    input  logic               sin_valid,
    input  logic [SLICE_W-1:0] sin,
    output logic               sin_ready,
    output logic               sout_valid,
    output logic [SLICE_W-1:0] sout,
    input  logic               sout_ready,
    output logic               busy,
    output logic               done
);
    logic [1:0]       state;
    logic [ZW-1:0]    z;
    logic [ZW-1:0]    z_prev;
    logic             all_in;
    logic [LANES-1:0] cur;
    logic [LANES-1:0] prev;
    logic [LANES-1:0] d;
    logic             par_hs;
    logic             sin_hs;
    logic             out_hs;

    // all_in blocks a 65th slice from sneaking in while slice 63 is still waiting to leave
    assign par_ready = state == LOAD;
    assign sin_ready = state == APPLY && !all_in && (!sout_valid || sout_ready);
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign par_hs    = par_valid && par_ready;
    assign sin_hs    = sin_valid && sin_ready;
    assign out_hs    = sout_valid && sout_ready;
    assign z_prev    = z - 1'b1;

    parity_buf u_buf (
        .clk     (clk),
        .we      (par_hs),
        .waddr   (z),
        .wdata   (par_in),
        .raddr_a (z),
        .rdata_a (cur),
        .raddr_b (z_prev),
        .rdata_b (prev)
    );

    for (genvar x = 0; x < LANES; x++) begin : g_d
        assign d[x] = cur[lane_step(x, 4)] ^ prev[lane_step(x, 1)];
    end

    // frame FSM, slice counter and the single-entry output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            z          <= '0;
            all_in     <= 1'b0;
            sout_valid <= 1'b0;
            sout       <= '0;
        end else begin
            if (state == IDLE && start) begin
                state <= LOAD;
                z     <= '0;
            end
            if (par_hs) begin
                z <= z + 1'b1;
                if (z == ZW'(DEPTH - 1)) state <= APPLY;
            end
            if (sin_hs) begin
                sout   <= sin ^ {5{d}};
                z      <= z + 1'b1;
                all_in <= z == ZW'(DEPTH - 1);
            end
            sout_valid <= sin_hs ? 1'b1 : (out_hs ? 1'b0 : sout_valid);
            if (state == APPLY && out_hs && all_in) state <= DONE;
            if (state == DONE) begin
                state  <= IDLE;
                all_in <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_theta_apply.sv
// tb_theta_apply: directed self-checking bench for theta_apply
module tb_theta_apply;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        par_valid = 1'b0;
    logic [4:0]  par_in = '0;
    logic        par_ready;
    logic        sin_valid = 1'b0;
    logic [24:0] sin = '0;
    logic        sin_ready;
    logic        sout_valid;
    logic [24:0] sout;
    logic        sout_ready = 1'b0;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [4:0]  pv [64];
    logic [24:0] sv [64];
    logic [24:0] ev [64];

    theta_apply dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .par_valid  (par_valid),
        .par_in     (par_in),
        .par_ready  (par_ready),
        .sin_valid  (sin_valid),
        .sin        (sin),
        .sin_ready  (sin_ready),
        .sout_valid (sout_valid),
        .sout       (sout),
        .sout_ready (sout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference theta: D[x][z] = C[x-1][z] ^ C[x+1][z-1], applied to every row
    task automatic compute_expected();
        for (int z = 0; z < 64; z++) begin
            for (int y = 0; y < 5; y++) begin
                for (int x = 0; x < 5; x++) begin
                    ev[z][5*y+x] = sv[z][5*y+x] ^ pv[z][(x+4)%5] ^ pv[(z+63)%64][(x+1)%5];
                end
            end
        end
    endtask

    task automatic do_load(input bit spam);
        int n = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("load_busy", busy, 1);
        check("load_par_ready", par_ready, 1);
        for (int cyc = 0; cyc < 400 && n < 64; cyc++) begin
            @(negedge clk);
            par_valid = (cyc % 5) != 2;
            par_in    = pv[n];
            start     = spam;
            sin_valid = 1'b1;
            #1;
            if (n == 0) check("load_sin_ready", sin_ready, 0);
            if (par_valid && par_ready) n++;
        end
        @(negedge clk);
        par_valid = 1'b0;
        sin_valid = 1'b0;
        start     = 1'b0;
        #1;
        check("load_count", n, 64);
        check("apply_par_ready", par_ready, 0);
        check("apply_sin_ready", sin_ready, 1);
    endtask

    task automatic do_apply(input bit bp, input bit spam, input int stop_after);
        int in_cnt = 0;
        int out_cnt = 0;
        int done_cnt = 0;
        int first_in = -1;
        int first_out = -1;
        int last_out = -1;
        bit held = 1'b0;
        bit fin = 1'b0;
        logic [24:0] hv = '0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            @(negedge clk);
            sout_ready = bp ? (cyc % 2 == 1) : 1'b1;
            sin_valid  = in_cnt < 64;
            sin        = (in_cnt < 64) ? sv[in_cnt] : '0;
            start      = spam && (cyc % 2 == 0);
            #1;
            if (held) begin
                check("hold_valid", sout_valid, 1);
                check("hold_data", sout, hv);
            end
            if (sout_valid && !sout_ready) check("stall_sin_ready", sin_ready, 0);
            held = sout_valid && !sout_ready;
            hv   = sout;
            if (sout_valid && first_out < 0) first_out = cyc;
            if (sout_valid && sout_ready) begin
                if (out_cnt < 64) check($sformatf("sout_z%0d", out_cnt), sout, ev[out_cnt]);
                out_cnt++;
                last_out = cyc;
            end
            if (sin_valid && sin_ready) begin
                if (first_in < 0) first_in = cyc;
                in_cnt++;
            end
            if (done) begin
                done_cnt++;
                fin = 1'b1;
            end
            if (stop_after > 0 && in_cnt >= stop_after) fin = 1'b1;
        end
        if (stop_after == 0) begin
            check("done_seen", done_cnt, 1);
            check("in_count", in_cnt, 64);
            check("out_count", out_cnt, 64);
            if (!bp) begin
                check("first_latency", first_out - first_in, 1);
                check("burst_span", last_out - first_out, 63);
            end
            @(negedge clk);
            start = 1'b0;
            sin_valid = 1'b0;
            #1;
            check("post_done_busy", busy, 0);
            check("post_done_done", done, 0);
            check("post_done_valid", sout_valid, 0);
        end
    endtask

    initial begin
        #1;
        check("rst_sout_valid", sout_valid, 0);
        check("rst_sout", sout, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_par_ready", par_ready, 0);
        check("rst_sin_ready", sin_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        par_valid = 1'b1;
        @(negedge clk);
        #1;
        check("idle_par_ready", par_ready, 0);
        check("idle_busy", busy, 0);
        par_valid = 1'b0;

        // 1: zero parities pass slices unchanged
        for (int i = 0; i < 64; i++) begin
            pv[i] = '0;
            sv[i] = 25'h0AAAAAA;
            ev[i] = 25'h0AAAAAA;
        end
        do_load(1'b0);
        do_apply(1'b0, 1'b0, 0);

        // 2: wrap-around, only buf[63] nonzero
        for (int i = 0; i < 64; i++) begin
            pv[i] = '0;
            sv[i] = '0;
            ev[i] = '0;
        end
        pv[63] = 5'b00001;
        ev[0]  = 25'h1084210;
        ev[63] = 25'h0210842;
        do_load(1'b0);
        do_apply(1'b0, 1'b0, 0);

        // 3: alternating backpressure with random data
        for (int i = 0; i < 64; i++) begin
            pv[i] = 5'($urandom);
            sv[i] = 25'($urandom);
        end
        compute_expected();
        do_load(1'b0);
        do_apply(1'b1, 1'b0, 0);

        // 4: full throughput with fresh data
        for (int i = 0; i < 64; i++) begin
            pv[i] = 5'($urandom);
            sv[i] = 25'($urandom);
        end
        compute_expected();
        do_load(1'b0);
        do_apply(1'b0, 1'b0, 0);

        // 5: reset after 20 slices, then a clean frame
        do_load(1'b0);
        do_apply(1'b0, 1'b0, 20);
        @(negedge clk);
        sin_valid = 1'b0;
        sout_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", sout_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sin_ready", sin_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("after_rst_busy", busy, 0);
        do_load(1'b0);
        do_apply(1'b0, 1'b0, 0);

        // 6: start spammed during LOAD and APPLY is ignored
        for (int i = 0; i < 64; i++) begin
            pv[i] = 5'($urandom);
            sv[i] = 25'($urandom);
        end
        compute_expected();
        do_load(1'b1);
        do_apply(1'b1, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
